// File: rtl/buffer_reader_pkg.sv
// Shared definitions for the frame readout path.
//   TX_W              : byte width of the tx_control handshake
//   DEF_RAM_ADDR_BITS : default sample RAM address width
//   DEF_BITS_ADC      : default sample width
//   state_t           : buffer_reader FSM states
//   tx_beat_t         : registered byte stage presented to tx_control
package buffer_reader_pkg;

    localparam int unsigned TX_W              = 8;
    localparam int unsigned DEF_RAM_ADDR_BITS = 12;
    localparam int unsigned DEF_BITS_ADC      = 8;
    localparam int unsigned NUM_W             = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_SENDING  = 2'd3
    } state_t;

    typedef struct packed {
        logic [TX_W-1:0] data;
        logic            rdy;
        logic            eof;
    } tx_beat_t;

endpackage

// File: rtl/buffer_addr_gen.sv
// Readout address generator: clamps the frame length to the RAM depth,
// derives the oldest-sample address from the write pointer, then walks the
// circular address space while counting samples still to send.
//   clk, rst     : clock, synchronous active-high reset
//   load         : latch start address and length from write_ptr/num_samples
//   advance      : step to the next sample
//   write_ptr    : next address the writer would fill
//   num_samples  : requested frame length
//   addr         : current read address
//   last         : exactly one sample remains
//   done         : no samples remain
module buffer_addr_gen
    import buffer_reader_pkg::*;
#(
    parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     advance,
    input  logic [RAM_ADDR_BITS-1:0] write_ptr,
    input  logic [NUM_W-1:0]         num_samples,
    output logic [RAM_ADDR_BITS-1:0] addr,
    output logic                     last,
    output logic                     done
);

    // One extra bit so a full-depth frame is representable.
    localparam int unsigned CNT_W     = RAM_ADDR_BITS + 1;
    localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_BITS;

    logic [CNT_W-1:0]         len_c;
    logic [CNT_W-1:0]         remaining;
    logic [RAM_ADDR_BITS-1:0] start_c;

    // Clamp to the RAM depth; start wraps naturally in RAM_ADDR_BITS arithmetic.
    always_comb begin
        if (32'(num_samples) >= RAM_DEPTH) begin
            len_c = CNT_W'(RAM_DEPTH);
        end else begin
            len_c = CNT_W'(num_samples);
        end
        start_c = write_ptr - len_c[RAM_ADDR_BITS-1:0];
    end

    // Address and remaining-sample counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= start_c;
            remaining <= len_c;
        end else if (advance && (remaining != '0)) begin
            addr      <= addr + RAM_ADDR_BITS'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last = (remaining == CNT_W'(1));
    assign done = (remaining == '0);

endmodule

// File: rtl/buffer_reader.sv
// Streams the captured frame out of the circular sample RAM to tx_control,
// oldest sample first, one byte per FETCH/CAPTURE/SENDING round.
//   clk, rst      : clock, synchronous active-high reset
//   num_samples   : frame length, latched on an accepted request
//   write_ptr     : writer's next address, latched on an accepted request
//   write_enable  : capture in progress (blocks requests)
//   rqst_data     : start readout pulse
//   stop          : abort readout, highest priority
//   busy          : frame in progress
//   rd_en/rd_addr : RAM read port; rd_data valid the cycle after rd_en
//   tx_data/tx_rdy/tx_eof/tx_ack : byte handshake to tx_control
module buffer_reader
    import buffer_reader_pkg::*;
#(
    parameter int unsigned BITS_ADC      = DEF_BITS_ADC,
    parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_W-1:0]         num_samples,
    input  logic [RAM_ADDR_BITS-1:0] write_ptr,
    input  logic                     write_enable,
    input  logic                     rqst_data,
    input  logic                     stop,
    output logic                     busy,
    output logic                     rd_en,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [BITS_ADC-1:0]      rd_data,
    output logic [TX_W-1:0]          tx_data,
    output logic                     tx_rdy,
    output logic                     tx_eof,
    input  logic                     tx_ack
);

    state_t   state, state_d;
    tx_beat_t tx_q, tx_d;
    logic     rd_en_d;
    logic     busy_d;
    logic     load_c;
    logic     advance_c;
    logic     last;
    logic     done;

    buffer_addr_gen #(
        .RAM_ADDR_BITS (RAM_ADDR_BITS)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load_c),
        .advance     (advance_c),
        .write_ptr   (write_ptr),
        .num_samples (num_samples),
        .addr        (rd_addr),
        .last        (last),
        .done        (done)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tx_q  <= '{data: '0, rdy: 1'b0, eof: 1'b1};
            rd_en <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            tx_q  <= tx_d;
            rd_en <= rd_en_d;
            busy  <= busy_d;
        end
    end

    // Next state and next register values; stop overrides every transition.
    always_comb begin
        state_d   = state;
        tx_d      = tx_q;
        rd_en_d   = 1'b0;
        busy_d    = busy;
        load_c    = 1'b0;
        advance_c = 1'b0;

        if (stop) begin
            state_d  = ST_IDLE;
            tx_d.rdy = 1'b0;
            tx_d.eof = 1'b1;
            busy_d   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rqst_data && !write_enable && (num_samples != '0)) begin
                        load_c   = 1'b1;
                        rd_en_d  = 1'b1;
                        busy_d   = 1'b1;
                        tx_d.eof = 1'b0;
                        state_d  = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Nothing left to read can only mean a corrupted counter; bail out.
                    if (done) begin
                        tx_d.eof = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    tx_d.data = TX_W'(rd_data);
                    tx_d.rdy  = 1'b1;
                    tx_d.eof  = last;
                    state_d   = ST_SENDING;
                end
                ST_SENDING: begin
                    if (tx_ack) begin
                        tx_d.rdy  = 1'b0;
                        advance_c = 1'b1;
                        if (last) begin
                            tx_d.eof = 1'b1;
                            busy_d   = 1'b0;
                            state_d  = ST_IDLE;
                        end else begin
                            tx_d.eof = 1'b0;
                            rd_en_d  = 1'b1;
                            state_d  = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data = tx_q.data;
    assign tx_rdy  = tx_q.rdy;
    assign tx_eof  = tx_q.eof;

endmodule

// File: tb/tb_buffer_reader.sv
// Scoreboard bench for buffer_reader with a 16-entry RAM preloaded as RAM[i] = 3*i.
module tb_buffer_reader;

    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   num_samples;
    logic [AW-1:0] write_ptr;
    logic          write_enable;
    logic          rqst_data;
    logic          stop;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          tx_rdy;
    logic          tx_eof;
    logic          tx_ack;

    buffer_reader #(
        .BITS_ADC      (8),
        .RAM_ADDR_BITS (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .num_samples  (num_samples),
        .write_ptr    (write_ptr),
        .write_enable (write_enable),
        .rqst_data    (rqst_data),
        .stop         (stop),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .tx_data      (tx_data),
        .tx_rdy       (tx_rdy),
        .tx_eof       (tx_eof),
        .tx_ack       (tx_ack)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency.
    logic [7:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(3 * i);
        rd_data = '0;
    end
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    typedef struct {
        int addr;
        int data;
        bit eof;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   last_rd_addr = -1;
    logic prev_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: oldest-first list of the len = min(n, DEPTH) samples ending just before wp.
    task automatic push_frame(input int wp, input int n, input int limit);
        int len, start, a;
        len   = (n > DEPTH) ? DEPTH : n;
        start = (((wp - len) % DEPTH) + DEPTH) % DEPTH;
        for (int k = 0; k < len && k < limit; k++) begin
            a = (start + k) % DEPTH;
            exp_q.push_back('{addr: a, data: (3 * a) % 256, eof: (k == len - 1)});
        end
    endtask

    // Monitor: each new byte presented by the DUT is compared with the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_rdy = 1'b0;
        end else begin
            if (rd_en) begin
                last_rd_addr = int'(rd_addr);
                check("rd_en_only_in_fetch", {30'd0, tx_rdy, busy}, 32'd1);
            end
            if (tx_rdy && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got data %0d eof %0d, expected none", tx_data, tx_eof);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rd_addr", last_rd_addr, e.addr);
                    check("tx_data", tx_data, e.data);
                    check("tx_eof", tx_eof, e.eof);
                end
            end
            prev_rdy = tx_rdy;
        end
    end

    task automatic wait_rdy(output int cyc, output bit got);
        cyc = 0;
        while (!tx_rdy && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        got = tx_rdy;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    // One readout; hold_idx stretches ack on that byte, stop_after>0 aborts after that many acks.
    task automatic run_frame(input int wp, input int n, input int hold_idx, input int stop_after);
        int   len, nb, cyc;
        bit   got;
        logic [7:0] hd;
        logic       he;
        len = (n > DEPTH) ? DEPTH : n;
        nb  = (stop_after > 0) ? stop_after : len;
        push_frame(wp, n, nb);
        write_ptr   = AW'(wp);
        num_samples = 16'(n);
        rqst_data   = 1'b1;
        @(posedge clk);
        #1 rqst_data = 1'b0;
        write_ptr   = AW'($urandom);
        num_samples = 16'($urandom_range(0, 40));
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        for (int b = 0; b < nb; b++) begin
            wait_rdy(cyc, got);
            if (!got) begin
                n_checks++;
                $display("FAIL rdy_timeout: byte %0d never presented, expected within 20 cycles", b);
                pulse_stop();
                exp_q.delete();
                return;
            end
            if (b == 0) check("first_rdy_latency", cyc + 1, 3);
            if (b == hold_idx) begin
                hd = tx_data;
                he = tx_eof;
                rqst_data = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk);
                    #1 rqst_data = 1'b0;
                    @(negedge clk);
                    check("hold_rdy", tx_rdy, 1);
                    check("hold_data", tx_data, hd);
                    check("hold_eof", tx_eof, he);
                    check("hold_no_rd_en", rd_en, 0);
                end
            end
            tx_ack = 1'b1;
            @(posedge clk);
            #1 tx_ack = 1'b0;
            if (stop_after > 0 && b == nb - 1) begin
                pulse_stop();
                @(negedge clk);
                check("stop_rdy", tx_rdy, 0);
                check("stop_eof", tx_eof, 1);
                check("stop_busy", busy, 0);
                return;
            end
        end
        @(negedge clk);
        check("end_busy", busy, 0);
        check("end_eof", tx_eof, 1);
    endtask

    // A request that must be ignored: no byte, busy stays low.
    task automatic ignored_request(input int wp, input int n, input bit we);
        write_ptr    = AW'(wp);
        num_samples  = 16'(n);
        write_enable = we;
        rqst_data    = 1'b1;
        @(posedge clk);
        #1 rqst_data = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ignored_busy", busy, 0);
            check("ignored_rdy", tx_rdy, 0);
        end
        write_enable = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; num_samples = '0; write_ptr = '0; write_enable = 1'b0;
        rqst_data = 1'b0; stop = 1'b0; tx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", tx_rdy, 0);
        check("rst_eof", tx_eof, 1);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_data", tx_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        tx_ack = 1'b1;
        @(posedge clk);
        #1 tx_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_rdy", tx_rdy, 0);
        check("idle_ack_eof", tx_eof, 1);
        check("idle_ack_busy", busy, 0);
        check("idle_ack_rd_en", rd_en, 0);

        run_frame(10, 4, -1, 0);
        run_frame(2, 5, -1, 0);
        run_frame(10, 4, 1, 0);
        run_frame(7, 40, -1, 0);
        ignored_request(5, 0, 1'b0);
        ignored_request(10, 4, 1'b1);
        run_frame(10, 6, -1, 2);
        run_frame(12, 3, -1, 0);

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_frame(int'($urandom_range(0, 15)), int'($urandom_range(1, 40)),
                      int'($urandom_range(0, 4)), 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
